// File: rtl/ibus2ocp_pf.sv
// Registered CPU instruction-bus to OCP read bridge with a one-entry sequential
// prefetch buffer; one OCP read outstanding at a time.
module ibus2ocp_pf #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_IAddr,
  input  logic                    i_IRdC,
  input  logic                    i_IFlush,
  output logic [DATA_WIDTH-1:0]   o_IData,
  output logic                    o_IRdy,
  output logic                    o_IErr,
  output logic [ADDR_WIDTH-1:0]   o_MAddr,
  output logic [2:0]              o_MCmd,
  output logic [DATA_WIDTH-1:0]   o_MData,
  output logic [DATA_WIDTH/8-1:0] o_MByteEn,
  input  logic                    i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0]   i_SData,
  input  logic [1:0]              i_SResp
);

  // state   | meaning
  // IDLE    | waiting for a CPU fetch; buffer hits complete from here
  // CMD     | demand READ presented, waiting for SCmdAccept
  // RESP    | demand READ accepted, waiting for SResp
  // DONE    | o_IRdy high; decide whether to prefetch the next word
  // PF_CMD  | speculative READ presented, waiting for SCmdAccept
  // PF_RESP | speculative READ accepted, waiting for SResp
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RESP, S_DONE, S_PF_CMD, S_PF_RESP
  } state_t;

  localparam int                  BEN_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] STRIDE    = (ADDR_WIDTH + 1)'(BEN_WIDTH);
  localparam logic [2:0]          OCP_IDLE  = 3'b000;
  localparam logic [2:0]          OCP_READ  = 3'b010;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   maddr_q;
  logic [2:0]              mcmd_q;
  logic [DATA_WIDTH-1:0]   idata_q;
  logic                    irdy_q;
  logic                    ierr_q;
  logic                    buf_valid_q;
  logic [ADDR_WIDTH-1:0]   buf_addr_q;
  logic [DATA_WIDTH-1:0]   buf_data_q;
  logic                    last_dva_q;
  logic                    promoted_q;
  logic                    pf_flushed_q;

  logic [ADDR_WIDTH:0]     next_addr;
  logic                    resp_valid;
  logic                    resp_dva;
  logic                    buf_hit;
  logic                    pf_match;
  logic                    pf_take;

  // carry out of next_addr marks a prefetch that would wrap past the top
  assign next_addr  = {1'b0, maddr_q} + STRIDE;
  assign resp_valid = (i_SResp != 2'b00);
  assign resp_dva   = (i_SResp == 2'b01);
  assign buf_hit    = buf_valid_q && !i_IFlush && (i_IAddr == buf_addr_q);
  // a flushed prefetch may hold stale data, so it is never promoted
  assign pf_match   = i_IRdC && (i_IAddr == maddr_q) && !pf_flushed_q && !i_IFlush;
  assign pf_take    = promoted_q || pf_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      maddr_q      <= '0;
      mcmd_q       <= OCP_IDLE;
      idata_q      <= '0;
      irdy_q       <= 1'b0;
      ierr_q       <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      last_dva_q   <= 1'b0;
      promoted_q   <= 1'b0;
      pf_flushed_q <= 1'b0;
    end else begin
      irdy_q <= 1'b0;
      ierr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_IRdC) begin
            if (buf_hit) begin
              idata_q     <= buf_data_q;
              irdy_q      <= 1'b1;
              buf_valid_q <= 1'b0;
              last_dva_q  <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              maddr_q <= i_IAddr;
              mcmd_q  <= OCP_READ;
              state_q <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (i_SCmdAccept) begin
            mcmd_q  <= OCP_IDLE;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_valid) begin
            idata_q    <= i_SData;
            irdy_q     <= 1'b1;
            ierr_q     <= !resp_dva;
            last_dva_q <= resp_dva;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (PREFETCH_EN && last_dva_q && !next_addr[ADDR_WIDTH]) begin
            maddr_q      <= next_addr[ADDR_WIDTH-1:0];
            mcmd_q       <= OCP_READ;
            promoted_q   <= 1'b0;
            pf_flushed_q <= 1'b0;
            state_q      <= S_PF_CMD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PF_CMD: begin
          if (pf_match) promoted_q <= 1'b1;
          if (i_SCmdAccept) begin
            mcmd_q  <= OCP_IDLE;
            state_q <= S_PF_RESP;
          end
        end
        S_PF_RESP: begin
          if (resp_valid) begin
            if (pf_take) begin
              idata_q    <= i_SData;
              irdy_q     <= 1'b1;
              ierr_q     <= !resp_dva;
              last_dva_q <= resp_dva;
              state_q    <= S_DONE;
            end else begin
              if (resp_dva && !pf_flushed_q && !i_IFlush) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= maddr_q;
                buf_data_q  <= i_SData;
              end
              state_q <= S_IDLE;
            end
          end else if (pf_match) begin
            promoted_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (i_IFlush) begin
        buf_valid_q <= 1'b0;
        if (state_q == S_PF_CMD || state_q == S_PF_RESP) pf_flushed_q <= 1'b1;
      end
    end
  end

  assign o_IData   = idata_q;
  assign o_IRdy    = irdy_q;
  assign o_IErr    = ierr_q;
  assign o_MAddr   = maddr_q;
  assign o_MCmd    = mcmd_q;
  assign o_MData   = '0;
  assign o_MByteEn = '1;

endmodule

// File: tb/tb_ibus2ocp_pf.sv
// Directed bench for ibus2ocp_pf with a small OCP slave model driven from the
// same process as the CPU stimulus.
module tb_ibus2ocp_pf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_IAddr;
  logic        i_IRdC;
  logic        i_IFlush;
  logic [31:0] o_IData;
  logic        o_IRdy;
  logic        o_IErr;
  logic [31:0] o_MAddr;
  logic [2:0]  o_MCmd;
  logic [31:0] o_MData;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData;
  logic [1:0]  i_SResp;

  int          tests = 0;
  int          fails = 0;
  int          reads = 0;
  logic [31:0] last_rd_addr = '0;
  int          resp_delay = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] err_addr = '0;
  logic [1:0]  err_code = 2'b00;
  logic        err_armed = 1'b0;

  ibus2ocp_pf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PREFETCH_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .i_IFlush(i_IFlush),
    .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
    .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
    .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    if (a == 32'h0000_0104) return 32'h1122_3344;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the slave answers accepted reads resp_delay cycles after accept.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = (o_MCmd == 3'b010) && i_SCmdAccept && !rst;
    a   = o_MAddr;
    @(posedge clk);
    #1;
    i_SResp = 2'b00;
    i_SData = '0;
    if (acc) begin
      pend = 1'b1; pend_cnt = resp_delay; pend_addr = a;
      reads++; last_rd_addr = a;
    end else if (pend && pend_cnt > 0) begin
      pend_cnt--;
    end
    if (pend && pend_cnt == 0) begin
      pend = 1'b0;
      i_SData = mem(pend_addr);
      if (err_armed && pend_addr == err_addr) begin
        i_SResp = err_code; err_armed = 1'b0;
      end else begin
        i_SResp = 2'b01;
      end
    end
  endtask

  task automatic drain(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_rdy(input string tag, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_IRdy && n < 60);
    i_IRdC = 1'b0;
    check({tag, "_rdy"}, 32'(o_IRdy), 32'd1);
    check({tag, "_data"}, o_IData, exp_data);
    check({tag, "_err"}, 32'(o_IErr), 32'(exp_err));
    if (exp_n >= 0) check({tag, "_lat"}, 32'(n), 32'(exp_n));
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                       input int exp_n);
    i_IAddr = addr;
    i_IRdC  = 1'b1;
    wait_rdy(tag, exp_data, 1'b0, exp_n);
  endtask

  initial begin
    rst = 1'b1; i_IAddr = '0; i_IRdC = 1'b0; i_IFlush = 1'b0;
    i_SCmdAccept = 1'b1; i_SData = '0; i_SResp = 2'b00;
    #1;
    tick(); tick();
    check("rst_mcmd", 32'(o_MCmd), 32'd0);
    check("rst_maddr", o_MAddr, 32'h0);
    check("rst_idata", o_IData, 32'h0);
    check("rst_irdy", 32'(o_IRdy), 32'd0);
    check("rst_ierr", 32'(o_IErr), 32'd0);
    check("mdata", o_MData, 32'h0);
    check("mbyteen", 32'(o_MByteEn), 32'hF);
    rst = 1'b0;

    // miss on zero-wait slave, then the sequential prefetch
    fetch("miss100", 32'h100, 32'hDEAD_BEEF, 3);
    tick();
    check("pf_mcmd", 32'(o_MCmd), 32'd2);
    check("pf_maddr", o_MAddr, 32'h104);
    check("irdy_pulse", 32'(o_IRdy), 32'd0);
    drain(2);
    check("reads_a", 32'(reads), 32'd2);

    // sequential hit from the buffer
    fetch("hit104", 32'h104, 32'h1122_3344, 1);
    tick();
    check("hit_nocmd", 32'(o_MCmd), 32'd0);
    check("reads_b", 32'(reads), 32'd2);

    // accept stall: command held while SCmdAccept is low
    i_SCmdAccept = 1'b0; i_IAddr = 32'h300; i_IRdC = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stall_mcmd", 32'(o_MCmd), 32'd2);
      check("stall_maddr", o_MAddr, 32'h300);
      tick();
    end
    check("stall_noirdy", 32'(o_IRdy), 32'd0);
    i_SCmdAccept = 1'b1;
    wait_rdy("stall300", mem(32'h300), 1'b0, 2);
    drain(3);
    check("reads_c", 32'(reads), 32'd4);

    // demand error: reported, no prefetch
    err_addr = 32'h200; err_code = 2'b11; err_armed = 1'b1;
    i_IAddr = 32'h200; i_IRdC = 1'b1;
    wait_rdy("err200", mem(32'h200), 1'b1, 3);
    tick();
    check("err_nopf1", 32'(o_MCmd), 32'd0);
    tick();
    check("err_nopf2", 32'(o_MCmd), 32'd0);
    check("reads_d", 32'(reads), 32'd5);

    // prefetch FAIL is silent and leaves nothing in the buffer
    err_addr = 32'h504; err_code = 2'b10; err_armed = 1'b1;
    fetch("miss500", 32'h500, mem(32'h500), 3);
    drain(3);
    check("pffail_irdy", 32'(o_IRdy), 32'd0);
    check("pffail_ierr", 32'(o_IErr), 32'd0);
    check("reads_e", 32'(reads), 32'd7);
    fetch("remiss504", 32'h504, mem(32'h504), 3);
    check("reads_f", 32'(reads), 32'd8);
    drain(3);

    // promotion while the prefetch awaits its response
    fetch("miss600", 32'h600, mem(32'h600), 3);
    resp_delay = 3;
    tick(); tick();
    i_IAddr = 32'h604; i_IRdC = 1'b1;
    wait_rdy("promo604", mem(32'h604), 1'b0, 4);
    check("promo_reads", 32'(reads), 32'd11);

    // branch away during a prefetch: prefetch completes first, then the demand
    tick();
    i_IAddr = 32'h400; i_IRdC = 1'b1;
    wait_rdy("branch400", mem(32'h400), 1'b0, 11);
    check("branch_reads", 32'(reads), 32'd13);
    check("branch_last", last_rd_addr, 32'h400);
    resp_delay = 0;
    drain(3);

    // flush during PF_RESP drops the prefetched word
    fetch("miss100b", 32'h100, 32'hDEAD_BEEF, 3);
    resp_delay = 2;
    tick(); tick();
    i_IFlush = 1'b1;
    tick();
    i_IFlush = 1'b0;
    tick(); tick();
    resp_delay = 0;
    fetch("flushmiss104", 32'h104, 32'h1122_3344, 3);
    check("reads_g", 32'(reads), 32'd17);
    drain(3);

    // flush and hit in the same cycle: treated as a miss
    i_IAddr = 32'h108; i_IRdC = 1'b1; i_IFlush = 1'b1;
    tick();
    i_IFlush = 1'b0;
    wait_rdy("flushhit108", mem(32'h108), 1'b0, 2);
    drain(3);
    check("reads_h", 32'(reads), 32'd20);

    // top of address space: no wrapping prefetch
    fetch("top", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 3);
    tick();
    check("top_nopf", 32'(o_MCmd), 32'd0);
    tick();
    check("top_reads", 32'(reads), 32'd21);

    // reset while waiting in RESP
    resp_delay = 3;
    i_IAddr = 32'h700; i_IRdC = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("mrst_mcmd", 32'(o_MCmd), 32'd0);
    check("mrst_maddr", o_MAddr, 32'h0);
    check("mrst_idata", o_IData, 32'h0);
    check("mrst_irdy", 32'(o_IRdy), 32'd0);
    check("mrst_ierr", 32'(o_IErr), 32'd0);
    pend = 1'b0; i_IRdC = 1'b0; resp_delay = 0;
    tick();
    rst = 1'b0;
    fetch("postrst10c", 32'h10C, mem(32'h10C), 3);
    drain(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
